// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, master FSM state type and the command legality rule.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } state_t;

  // A command is legal when its size is byte/half/word and its address is
  // naturally aligned for that size.
  function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: replicates narrow write data onto every lane and pulls
// the addressed lane out of read data, zero-extended.
module ahb_lane_align
  import ahb_lite_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_lane
);

  // Select replication and extraction pattern from transfer size and low address bits
  always_comb begin
    wdata_lanes = wdata;
    rdata_lane  = rdata;
    case (size)
      HSIZE_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    rdata_lane = {24'h0, rdata[7:0]};
          2'd1:    rdata_lane = {24'h0, rdata[15:8]};
          2'd2:    rdata_lane = {24'h0, rdata[23:16]};
          default: rdata_lane = {24'h0, rdata[31:24]};
        endcase
      end
      HSIZE_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        rdata_lane  = addr_lo[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      end
      default: begin
        wdata_lanes = wdata;
        rdata_lane  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: converts one command handshake into
// one bus transfer and returns a single-cycle completion pulse.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [1:0]            hsize,
  output logic                  hwrite,
  output logic [31:0]           hwdata,
  input  logic [31:0]           hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  state_t      state;
  logic [31:0] wdata_q;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_lane;

  // The captured haddr/hsize stay valid through the data phase, so they steer lanes
  ahb_lane_align u_align (
    .size        (hsize),
    .addr_lo     (haddr[1:0]),
    .wdata       (wdata_q),
    .rdata       (hrdata),
    .wdata_lanes (wdata_lanes),
    .rdata_lane  (rdata_lane)
  );

  // Transfer sequencer; every output is a register so the bus sees clean edges
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      hsel      <= 1'b0;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hsize     <= HSIZE_BYTE;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
              state     <= ST_ADDR;
              cmd_ready <= 1'b0;
              hsel      <= 1'b1;
              htrans    <= HTRANS_NONSEQ;
              haddr     <= cmd_addr;
              hsize     <= cmd_size;
              hwrite    <= cmd_write;
              wdata_q   <= cmd_wdata;
            end else begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            state  <= ST_DATA;
            hsel   <= 1'b0;
            htrans <= HTRANS_IDLE;
            hwdata <= hwrite ? wdata_lanes : '0;
          end
        end
        ST_DATA: begin
          if (hresp) begin
            if (hready) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ST_ERR;
            end
          end else if (hready) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= hwrite ? '0 : rdata_lane;
          end
        end
        ST_ERR: begin
          if (hready) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: a transaction-level model predicts
// every cycle's outputs, and one compare process checks them at each negedge.
module tb_ahb_lite_master;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int vectors;
  int miscompares;
  bit check_en;

  // Expected outputs for the current cycle, plus flags for which are meaningful
  logic        e_cmd_ready;
  logic        e_rsp_valid;
  bit          e_chk_rsp;
  logic        e_rsp_error;
  logic [31:0] e_rsp_rdata;
  logic        e_hsel;
  logic [1:0]  e_htrans;
  bit          e_chk_bus;
  logic [3:0]  e_haddr;
  logic [1:0]  e_hsize;
  logic        e_hwrite;
  bit          e_chk_wdata;
  logic [31:0] e_hwdata;

  ahb_lite_master #(.ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: legal when size < 3 and the address is a multiple of the transfer size
  function automatic bit m_legal(input int size, input int addr);
    if (size == 3) return 1'b0;
    return (addr % (1 << size)) == 0;
  endfunction

  // Model: narrow write data copied into every lane by multiplication
  function automatic logic [31:0] m_rep(input int size, input logic [31:0] d);
    if (size == 0) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (size == 1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Model: shift the addressed byte offset down to bit 0, then mask to size
  function automatic logic [31:0] m_ext(input int size, input int addr, input logic [31:0] bus);
    logic [31:0] sh;
    sh = bus >> (8 * (addr % 4));
    if (size == 0) return sh & 32'h0000_00FF;
    if (size == 1) return sh & 32'h0000_FFFF;
    return bus;
  endfunction

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_cmd_ready = 1'b1; e_rsp_valid = 1'b0; e_chk_rsp = 1'b0;
    e_rsp_error = 1'b0; e_rsp_rdata = '0;
    e_hsel = 1'b0; e_htrans = 2'b00; e_chk_bus = 1'b0;
    e_haddr = '0; e_hsize = '0; e_hwrite = 1'b0;
    e_chk_wdata = 1'b0; e_hwdata = '0;
  endtask

  task automatic set_reset_exp();
    set_idle_exp();
    e_chk_rsp = 1'b1;
    e_chk_bus = 1'b1;
    e_chk_wdata = 1'b1;
  endtask

  // Compare every expected output against the DUT once per cycle, mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      check_output("cmd_ready", cmd_ready, e_cmd_ready);
      check_output("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid || e_chk_rsp) begin
        check_output("rsp_error", rsp_error, e_rsp_error);
        check_output("rsp_rdata", rsp_rdata, e_rsp_rdata);
      end
      check_output("hsel", hsel, e_hsel);
      check_output("htrans", htrans, e_htrans);
      if (e_chk_bus) begin
        check_output("haddr", haddr, e_haddr);
        check_output("hsize", hsize, e_hsize);
        check_output("hwrite", hwrite, e_hwrite);
      end
      if (e_chk_wdata) check_output("hwdata", hwdata, e_hwdata);
    end
  end

  task automatic idle_cycle();
    next_cycle();
    set_idle_exp();
    hrdata = $urandom;
  endtask

  // One command from offer to completion; aw/dw/ew are wait states in the
  // address, data and error phases; em: 0 okay, 1 two-cycle error, 2 one-cycle error
  task automatic apply_stimulus(input logic wr, input logic [3:0] addr, input logic [1:0] size,
                                input logic [31:0] wd, input logic [31:0] rd_bus,
                                input int aw, input int dw, input int em, input int ew,
                                output logic [31:0] got_rdata, output logic got_err,
                                output logic [31:0] got_hwdata, output logic [1:0] got_hsize);
    bit legal;
    logic [31:0] exp_w;
    logic [31:0] sampled;
    legal = m_legal(int'(size), int'(addr));
    exp_w = m_rep(int'(size), wd);
    sampled = '0;
    got_hwdata = '0;
    got_hsize = '0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wd;
    hready = 1'b1; hresp = 1'b0;
    next_cycle();
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    if (!legal) begin
      set_idle_exp();
      e_rsp_valid = 1'b1; e_rsp_error = 1'b1; e_rsp_rdata = '0;
      got_rdata = rsp_rdata;
      got_err = rsp_error;
      return;
    end
    for (int i = 0; i <= aw; i++) begin
      if (i > 0) next_cycle();
      set_idle_exp();
      e_cmd_ready = 1'b0; e_hsel = 1'b1; e_htrans = 2'b10;
      e_chk_bus = 1'b1; e_haddr = addr; e_hsize = size; e_hwrite = wr;
      got_hsize = hsize;
      hready = (i == aw); hresp = 1'b0; hrdata = $urandom;
    end
    for (int i = 0; i <= dw; i++) begin
      next_cycle();
      set_idle_exp();
      e_cmd_ready = 1'b0;
      e_chk_wdata = wr; e_hwdata = exp_w;
      if (i == 0) got_hwdata = hwdata;
      hrdata = $urandom;
      if (i < dw) begin
        hready = 1'b0; hresp = 1'b0;
      end else if (em == 0) begin
        hready = 1'b1; hresp = 1'b0; hrdata = rd_bus; sampled = rd_bus;
      end else if (em == 1) begin
        hready = 1'b0; hresp = 1'b1;
      end else begin
        hready = 1'b1; hresp = 1'b1;
      end
    end
    if (em == 1) begin
      for (int i = 0; i <= ew; i++) begin
        next_cycle();
        set_idle_exp();
        e_cmd_ready = 1'b0;
        hready = (i == ew); hresp = 1'b1; hrdata = $urandom;
      end
    end
    next_cycle();
    set_idle_exp();
    e_rsp_valid = 1'b1;
    e_rsp_error = (em != 0);
    e_rsp_rdata = (em != 0 || wr) ? 32'h0 : m_ext(int'(size), int'(addr), sampled);
    got_rdata = rsp_rdata;
    got_err = rsp_error;
    hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
  endtask

  logic [31:0] g_rd;
  logic        g_err;
  logic [31:0] g_wd;
  logic [1:0]  g_sz;

  initial begin
    vectors = 0;
    miscompares = 0;
    n_rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    set_reset_exp();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle_cycle();

    $display("[TB] directed: word write");
    apply_stimulus(1'b1, 4'h4, 2'd2, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_word_hwdata", g_wd, 32'hDEADBEEF);
    check_output("lit_word_err", g_err, 1'b0);
    idle_cycle();

    $display("[TB] directed: byte read with two data waits");
    apply_stimulus(1'b0, 4'h6, 2'd0, 32'h0, 32'h11223344, 0, 2, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_byte_rdata", g_rd, 32'h0000_0022);
    idle_cycle();

    $display("[TB] directed: halfword write");
    apply_stimulus(1'b1, 4'h2, 2'd1, 32'h0000ABCD, 32'h0, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_half_hwdata", g_wd, 32'hABCDABCD);
    check_output("lit_half_hsize", g_sz, 2'd1);
    idle_cycle();

    $display("[TB] directed: two-cycle error then back-to-back command");
    apply_stimulus(1'b0, 4'h8, 2'd2, 32'h0, 32'hFFFF_FFFF, 0, 0, 1, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_err_flag", g_err, 1'b1);
    check_output("lit_err_rdata", g_rd, 32'h0);
    apply_stimulus(1'b0, 4'h0, 2'd2, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_after_err_rdata", g_rd, 32'h0BAD_F00D);

    $display("[TB] directed: illegal commands");
    apply_stimulus(1'b0, 4'h3, 2'd2, 32'h0, 32'h0, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_misaligned_err", g_err, 1'b1);
    apply_stimulus(1'b1, 4'h0, 2'd3, 32'h1234, 32'h0, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_size3_err", g_err, 1'b1);
    idle_cycle();

    $display("[TB] directed: reset during data wait");
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8; cmd_size = 2'd2;
    next_cycle();
    cmd_valid = 1'b0;
    set_idle_exp();
    e_cmd_ready = 1'b0; e_hsel = 1'b1; e_htrans = 2'b10;
    e_chk_bus = 1'b1; e_haddr = 4'h8; e_hsize = 2'd2; e_hwrite = 1'b0;
    hready = 1'b1;
    next_cycle();
    set_idle_exp();
    e_cmd_ready = 1'b0;
    hready = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check_output("rst_now_cmd_ready", cmd_ready, 1'b1);
    check_output("rst_now_rsp_valid", rsp_valid, 1'b0);
    check_output("rst_now_haddr", haddr, 4'h0);
    set_reset_exp();
    next_cycle();
    n_rst = 1'b1;
    hready = 1'b1;
    apply_stimulus(1'b0, 4'hC, 2'd2, 32'h0, 32'hCAFE_1234, 0, 0, 0, 0, g_rd, g_err, g_wd, g_sz);
    check_output("lit_post_rst_rdata", g_rd, 32'hCAFE_1234);
    idle_cycle();

    $display("[TB] randomized transactions");
    for (int n = 0; n < 400; n++) begin
      int r;
      int em;
      r = $urandom_range(0, 9);
      em = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), em,
                     $urandom_range(0, 2), g_rd, g_err, g_wd, g_sz);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-outstanding AHB-Lite initiator that turns simple command/response handshakes into bus transfers. It drives the AHB-Lite slave port of the USB endpoint (`hsel`/`haddr`/`htrans`/`hsize`/`hwrite`/`hwdata` out; `hrdata`/`hready`/`hresp` in). It serves as the bus-side driver for system-level simulation and as the embedded controller's path into the endpoint register map.

## Interface
- `ADDR_WIDTH`, 4, width of `cmd_addr` and `haddr`.
- `clk` in 1: rising-edge clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: master can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: byte address.
- `cmd_size` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `cmd_wdata` in 32: write data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: read data, right-justified, zero-extended. 0 for writes and errors.
- `rsp_error` out 1: completion is an error.
- `hsel` out 1, `haddr` out ADDR_WIDTH, `htrans` out 2, `hsize` out 2, `hwrite` out 1, `hwdata` out 32: AHB-Lite master outputs.
- `hrdata` in 32, `hready` in 1, `hresp` in 1: AHB-Lite slave responses.

## Operation
- FSM states: IDLE, ADDR, DATA, ERR.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, capture the command.
  - Illegal or misaligned command: next cycle is IDLE with `rsp_valid`=1, `rsp_error`=1, and no bus activity. A command is misaligned when `cmd_size`=3, or halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Legal command: go to ADDR.
- **ADDR**
  - Drive `hsel`=1, `htrans`=NONSEQ (2'b10), `haddr`, `hsize`, `hwrite`.
  - Hold all of these until `hready`=1 is sampled, then go to DATA.
- **DATA**
  - Drive `hsel`=0, `htrans`=IDLE.
  - For writes, `hwdata` carries the lane-replicated data and is held stable while `hready`=0. Byte data is replicated ×4; halfword data is replicated ×2.
  - `hready`=1, `hresp`=0: go to IDLE with `rsp_valid`=1.
    - Reads return `hrdata` lane-extracted and zero-extended. Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - `hready`=0, `hresp`=1: first cycle of an error response; go to ERR.
  - `hready`=1, `hresp`=1 (a one-cycle error): treat as an error completion.
- **ERR**
  - Wait for `hready`=1.
  - Then go to IDLE with `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0.
- `cmd_ready` is 1 only in IDLE. That includes the `rsp_valid` cycle, so back-to-back commands are allowed.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous reset). An in-flight transfer is abandoned with no response.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_error`=0, `rsp_rdata`=0.
  - `hsel`=0, `htrans`=2'b00, `haddr`=0, `hsize`=0, `hwrite`=0, `hwdata`=0.
- Cycle T: command accepted.
- T+1: address phase.
- T+2: data phase.
- T+3: `rsp_valid` pulse, when there are zero wait states.
- Each cycle with `hready`=0 adds one cycle of latency.
- Local error: `rsp_valid` at T+1.
- Peak throughput: one transfer per 3 cycles.
- `rsp_rdata` and `rsp_error` are valid only while `rsp_valid`=1.

## Structure
- Package `ahb_lite_pkg` holds:
  - `htrans` constants: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - `hsize` constants: BYTE=0, HALF=1, WORD=2.
  - FSM state typedef.
- Sub-module `ahb_lane_align` (combinational) performs write replication and read extraction from size and `addr[1:0]`.
- The FSM and registers stay in `ahb_lite_master`.

## Test plan
- Word write, address 0x4, data 0xDEADBEEF, zero waits:
  - T+1: `htrans`=2'b10, `haddr`=4, `hwrite`=1.
  - T+2: `hwdata`=0xDEADBEEF.
  - T+3: `rsp_valid`=1, `rsp_error`=0.
- Byte read, address 0x6, `hrdata`=0x11223344, two wait states in DATA:
  - `rsp_rdata`=0x00000022 at T+5.
  - `hwdata` and `htrans` are stable during the waits.
- Halfword write, address 0x2, data 0xABCD: `hwdata`=0xABCDABCD, `hsize`=1.
- Error response:
  - In DATA, `hready`=0/`hresp`=1, then `hready`=1/`hresp`=1.
  - Required: `rsp_error`=1, `rsp_rdata`=0, the ERR state is visited, and the next command is accepted the same cycle.
- Illegal commands, word at address 0x3 and then size 3:
  - `rsp_valid`/`rsp_error` at T+1.
  - `hsel` and `htrans` are never asserted.
- `n_rst` asserted during the DATA wait state:
  - All outputs are at reset values within the same cycle.
  - After release, a new word read completes normally.
